// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: the state enum
// (EMPTY/FULL/SKID), the occupancy encodings and a state-to-occupancy helper.
package pipe_pkg;

    // Stage state; the value 2'd3 is never entered and is steered back to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Occupancy encodings, number of held beats.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd1;
    localparam logic [1:0] OCC_SKID  = 2'd2;

    // Map a state to its occupancy encoding; unknown states read as empty.
    function automatic logic [1:0] occ_of_state(input pipe_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = OCC_EMPTY;
            ST_FULL:  occ = OCC_FULL;
            ST_SKID:  occ = OCC_SKID;
            default:  occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the backpressure statistic. It counts
// cycles with inc high, sticks at all-ones, and clears only on reset.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             at_max_s;
    logic [WIDTH-1:0] count_r;

    // Detect saturation so the counter never wraps.
    always_comb begin
        at_max_s = 1'b0;
        if (count_r == CNT_MAX) begin
            at_max_s = 1'b1;
        end else begin
            at_max_s = 1'b0;
        end
    end

    // Counter register: synchronous clear, increment until saturated.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && !at_max_s) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with valid/ready on both
// sides. in_ready, out_valid and occupancy are registered copies derived from
// the next state, so no input reaches an output combinationally. out_data is
// the main register. Optional feature: define PIPE_STAGE_STATS_EN to add the
// stall_cnt port, a saturating count of cycles with out_valid & !out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    pipe_state_e       state_r;
    pipe_state_e       next_state_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] skid_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [1:0]        occupancy_r;

    logic              in_fire_s;
    logic              out_fire_s;
    logic              load_main_s;
    logic              load_skid_s;
    logic              skid_to_main_s;

    // Handshake fire terms, built only from registered ready/valid.
    always_comb begin
        in_fire_s  = in_valid & in_ready_r;
        out_fire_s = out_valid_r & out_ready;
    end

    // Next-state and datapath-enable decode; flush overrides every handshake
    // move and suppresses any load, so a same-cycle input beat is dropped.
    always_comb begin
        next_state_s   = state_r;
        load_main_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_main_s = 1'b0;
        if (flush) begin
            next_state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        load_main_s  = 1'b1;
                        next_state_s = ST_FULL;
                    end else begin
                        next_state_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    case ({in_fire_s, out_fire_s})
                        2'b11: begin
                            load_main_s  = 1'b1;
                            next_state_s = ST_FULL;
                        end
                        2'b10: begin
                            load_skid_s  = 1'b1;
                            next_state_s = ST_SKID;
                        end
                        2'b01: begin
                            next_state_s = ST_EMPTY;
                        end
                        default: begin
                            next_state_s = ST_FULL;
                        end
                    endcase
                end
                ST_SKID: begin
                    if (out_fire_s) begin
                        skid_to_main_s = 1'b1;
                        next_state_s   = ST_FULL;
                    end else begin
                        next_state_s = ST_SKID;
                    end
                end
                default: begin
                    next_state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus registered status outputs derived from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= OCC_EMPTY;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != ST_SKID);
            out_valid_r <= (next_state_s != ST_EMPTY);
            occupancy_r <= occ_of_state(next_state_s);
        end
    end

    // Payload registers; flush changes only the state, never the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_r <= {DATA_W{1'b0}};
            skid_r <= {DATA_W{1'b0}};
        end else begin
            if (load_main_s) begin
                main_r <= in_data;
            end else if (skid_to_main_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = occupancy_r;

`ifdef PIPE_STAGE_STATS_EN
    logic stall_inc_s;

    // A stall cycle is a held beat that downstream refuses.
    always_comb begin
        stall_inc_s = out_valid_r & ~out_ready;
    end

    pipe_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );
`endif

endmodule
